// File: rtl/text_pkg.sv
// Shared constants, control codes and encodings for the text tile write path.
package text_pkg;
  localparam int H_TILES        = 128;
  localparam int V_TILES        = 48;
  localparam int NUM_TILES      = H_TILES * V_TILES;
  localparam int ADDR_COL_WIDTH = 7;
  localparam int ADDR_ROW_WIDTH = 6;
  localparam int DATA_WIDTH     = 7;

  localparam logic [DATA_WIDTH-1:0] CH_BS  = 7'h08;
  localparam logic [DATA_WIDTH-1:0] CH_LF  = 7'h0A;
  localparam logic [DATA_WIDTH-1:0] CH_FF  = 7'h0C;
  localparam logic [DATA_WIDTH-1:0] CH_CR  = 7'h0D;
  localparam logic [DATA_WIDTH-1:0] CH_SP  = 7'h20;
  localparam logic [DATA_WIDTH-1:0] CH_DEL = 7'h7F;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  // Position update requested from a tile_cursor for the coming edge.
  typedef enum logic [2:0] {
    OP_NOP,
    OP_ADV,
    OP_NL,
    OP_CR,
    OP_BACK,
    OP_HOME
  } cur_op_e;
endpackage

// File: rtl/text_write_ctrl_tile_cursor.sv
// Column/row position register with advance, newline, carriage return,
// backspace and home operations. Wraps at the tile grid edges without scrolling.
module tile_cursor
  import text_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  cur_op_e                   op_i,
  output logic [ADDR_COL_WIDTH-1:0] col_o,
  output logic [ADDR_ROW_WIDTH-1:0] row_o,
  output logic                      last_o
);
  logic [ADDR_COL_WIDTH-1:0] col_q, col_d;
  logic [ADDR_ROW_WIDTH-1:0] row_q, row_d;
  logic                      col_end, row_end;
  logic [ADDR_ROW_WIDTH-1:0] row_nxt;

  assign col_end = (col_q == ADDR_COL_WIDTH'(H_TILES - 1));
  assign row_end = (row_q == ADDR_ROW_WIDTH'(V_TILES - 1));
  assign row_nxt = row_end ? '0 : row_q + ADDR_ROW_WIDTH'(1);

  // Next position for the requested operation.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    case (op_i)
      OP_ADV: begin
        if (col_end) begin
          col_d = '0;
          row_d = row_nxt;
        end else begin
          col_d = col_q + ADDR_COL_WIDTH'(1);
        end
      end
      OP_NL: begin
        col_d = '0;
        row_d = row_nxt;
      end
      OP_CR:   col_d = '0;
      OP_BACK: if (col_q != '0) col_d = col_q - ADDR_COL_WIDTH'(1);
      OP_HOME: begin
        col_d = '0;
        row_d = '0;
      end
      default: ;
    endcase
  end

  // Position register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = col_end && row_end;
endmodule

// File: rtl/text_write_ctrl.sv
// Write sequencer for the 128x48 character tile buffer: consumes an ASCII
// stream, interprets control codes, tracks the cursor and runs the clear sweep.
// Optional cursor blink is enabled with the CURSOR_BLINK_EN macro.
module text_write_ctrl
  import text_pkg::*;
`ifdef CURSOR_BLINK_EN
#(
  parameter int BLINK_CYCLES = 32500000
)
`endif
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      char_valid_i,
  input  logic [DATA_WIDTH-1:0]     char_i,
  output logic                      char_ready_o,
  input  logic                      clear_i,
  output logic                      busy_o,
  output logic                      wr_en_o,
  output logic [ADDR_COL_WIDTH-1:0] col_w_o,
  output logic [ADDR_ROW_WIDTH-1:0] row_w_o,
  output logic [DATA_WIDTH-1:0]     din_o,
  output logic [ADDR_COL_WIDTH-1:0] cur_col_o,
  output logic [ADDR_ROW_WIDTH-1:0] cur_row_o,
  output logic                      cur_vis_o
);
  state_e                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      wr_q, wr_d;
  logic [ADDR_COL_WIDTH-1:0] col_w_q, col_w_d;
  logic [ADDR_ROW_WIDTH-1:0] row_w_q, row_w_d;
  logic [DATA_WIDTH-1:0]     din_q, din_d;

  cur_op_e                   cur_op, swp_op;
  logic [ADDR_COL_WIDTH-1:0] cur_col, swp_col;
  logic [ADDR_ROW_WIDTH-1:0] cur_row, swp_row;
  logic                      cur_last, swp_last;
  logic                      accept;

  // Text cursor.
  tile_cursor u_cur (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .op_i  (cur_op),
    .col_o (cur_col),
    .row_o (cur_row),
    .last_o(cur_last)
  );

  // Clear sweep address; wraps back to (0,0) on its final advance.
  tile_cursor u_swp (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .op_i  (swp_op),
    .col_o (swp_col),
    .row_o (swp_row),
    .last_o(swp_last)
  );

  assign char_ready_o = (state_q == ST_IDLE) && !clear_i;
  assign accept       = char_valid_i && char_ready_o;

  // Decode the accepted code or step the sweep; computes the next write.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    wr_d    = 1'b0;
    col_w_d = col_w_q;
    row_w_d = row_w_q;
    din_d   = din_q;
    cur_op  = OP_NOP;
    swp_op  = OP_NOP;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
        end else if (accept) begin
          if (char_i >= CH_SP && char_i < CH_DEL) begin
            wr_d    = 1'b1;
            col_w_d = cur_col;
            row_w_d = cur_row;
            din_d   = char_i;
            cur_op  = OP_ADV;
          end else begin
            case (char_i)
              CH_LF: cur_op = OP_NL;
              CH_CR: cur_op = OP_CR;
              CH_BS: begin
                if (cur_col != '0) begin
                  cur_op  = OP_BACK;
                  wr_d    = 1'b1;
                  col_w_d = cur_col - ADDR_COL_WIDTH'(1);
                  row_w_d = cur_row;
                  din_d   = '0;
                end
              end
              CH_FF: begin
                state_d = ST_CLEAR;
                busy_d  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        wr_d    = 1'b1;
        col_w_d = swp_col;
        row_w_d = swp_row;
        din_d   = '0;
        swp_op  = OP_ADV;
        if (swp_last) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cur_op  = OP_HOME;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      col_w_q <= '0;
      row_w_q <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      col_w_q <= col_w_d;
      row_w_q <= row_w_d;
      din_q   <= din_d;
    end
  end

  assign busy_o    = busy_q;
  assign wr_en_o   = wr_q;
  assign col_w_o   = col_w_q;
  assign row_w_o   = row_w_q;
  assign din_o     = din_q;
  assign cur_col_o = cur_col;
  assign cur_row_o = cur_row;

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] blink_q;
  logic          vis_q;

  // Blink timer; any cursor move restarts it with the cursor shown.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_q <= '0;
      vis_q   <= 1'b1;
    end else if (cur_op != OP_NOP) begin
      blink_q <= '0;
      vis_q   <= 1'b1;
    end else if (blink_q == BW'(BLINK_CYCLES - 1)) begin
      blink_q <= '0;
      vis_q   <= ~vis_q;
    end else begin
      blink_q <= blink_q + BW'(1);
    end
  end

  assign cur_vis_o = vis_q;
`else
  assign cur_vis_o = 1'b1;
`endif
endmodule
